// File: rtl/word_mem_bridge_pkg.sv
// word_mem_bridge shared types.
// State encoding, access sizes and lane helpers.
package word_mem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        TAIL,
        DONE
    } state_t;

    localparam logic SIZE_BYTE  = 1'b0;
    localparam logic SIZE_WORD  = 1'b1;
    localparam int   WORD_BYTES = 4;

    // Index of the final lane for an access size.
    function automatic logic [1:0] last_idx(input logic size);
        return (size == SIZE_WORD) ? 2'(WORD_BYTES - 1) : 2'd0;
    endfunction

    // Selects byte lane idx of a 32-bit word.
    function automatic logic [7:0] lane_byte(
        input logic [31:0] w,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        unique case (idx)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/word_mem_bridge_assembler.sv
// byte_lane_assembler: gathers RAM read bytes into a word.
// Result includes the byte captured this cycle.
module byte_lane_assembler
    import word_mem_bridge_pkg::*;
#(
    parameter int SIGN_EXT_BYTE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_en,
    input  logic [1:0]  lane,
    input  logic [7:0]  rdata,
    input  logic        size,
    output logic [31:0] result
);

    logic [31:0] asm_q;
    logic [31:0] asm_d;
    logic        ext_bit;

    // Merge the incoming byte into its lane.
    always_comb begin
        asm_d = asm_q;
        if (cap_en) begin
            unique case (lane)
                2'd0: asm_d[7:0]   = rdata;
                2'd1: asm_d[15:8]  = rdata;
                2'd2: asm_d[23:16] = rdata;
                default: asm_d[31:24] = rdata;
            endcase
        end
    end

    // Assembly register.
    always_ff @(posedge clk) begin
        if (rst) begin
            asm_q <= '0;
        end else begin
            asm_q <= asm_d;
        end
    end

    // Pack word loads, extend byte loads.
    always_comb begin
        ext_bit = (SIGN_EXT_BYTE != 0) ? asm_d[7] : 1'b0;
        if (size == SIZE_WORD) begin
            result = asm_d;
        end else begin
            result = {{24{ext_bit}}, asm_d[7:0]};
        end
    end

endmodule

// File: rtl/word_mem_bridge.sv
// word_mem_bridge: 32-bit CPU port onto byte-wide RAM.
// Splits each access into 1 or 4 little-endian byte cycles.
module word_mem_bridge
    import word_mem_bridge_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int SIGN_EXT_BYTE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_size,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    state_t            state_q;
    state_t            state_d;
    logic [1:0]        idx_q;
    logic [ADDR_W-1:0] base_q;
    logic              we_q;
    logic              size_q;
    logic [31:0]       wdata_q;
    logic              cap_en;
    logic [1:0]        cap_lane;
    logic [31:0]       asm_result;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^cpu_addr[31:ADDR_W];

    // Request latch, lane index, and load result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 2'd0;
            base_q    <= '0;
            we_q      <= 1'b0;
            size_q    <= SIZE_BYTE;
            wdata_q   <= '0;
            cpu_rdata <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                IDLE: begin
                    if (cpu_req) begin
                        base_q  <= cpu_addr[ADDR_W-1:0];
                        we_q    <= cpu_we;
                        size_q  <= cpu_size;
                        wdata_q <= cpu_wdata;
                        idx_q   <= 2'd0;
                    end
                end
                XFER: begin
                    if (idx_q != last_idx(size_q)) begin
                        idx_q <= idx_q + 2'd1;
                    end
                end
                TAIL: begin
                    cpu_rdata <= asm_result;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state, RAM drive and CPU handshake.
    always_comb begin
        state_d   = state_q;
        ram_addr  = '0;
        ram_wdata = 8'd0;
        ram_we    = 1'b0;
        cap_en    = 1'b0;
        cap_lane  = idx_q - 2'd1;
        cpu_busy  = 1'b0;
        cpu_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                cpu_busy  = 1'b1;
                ram_addr  = base_q + ADDR_W'(idx_q);
                ram_we    = we_q & ~rst;
                ram_wdata = lane_byte(wdata_q, idx_q);
                if (!we_q && idx_q != 2'd0) begin
                    cap_en = 1'b1;
                end
                if (idx_q == last_idx(size_q)) begin
                    state_d = we_q ? DONE : TAIL;
                end
            end
            TAIL: begin
                cpu_busy = 1'b1;
                cap_en   = 1'b1;
                cap_lane = last_idx(size_q);
                state_d  = DONE;
            end
            DONE: begin
                cpu_busy = 1'b1;
                cpu_done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    byte_lane_assembler #(
        .SIGN_EXT_BYTE(SIGN_EXT_BYTE)
    ) u_asm (
        .clk   (clk),
        .rst   (rst),
        .cap_en(cap_en),
        .lane  (cap_lane),
        .rdata (ram_rdata),
        .size  (size_q),
        .result(asm_result)
    );

endmodule

// File: doc/word_mem_bridge.md
Name: word_mem_bridge

Overview:
Sits between the CPU data port and the 8-bit byte-wide data RAM. Converts each 32-bit load/store request into 1 or 4 sequential byte accesses on the RAM, and holds the CPU off with busy/done. Word accesses are little-endian. Byte loads are sign-extended to 32 bits, the same extension the processor applies today.

Parameters:
ADDR_W, 10, RAM byte-address width; CPU addresses are truncated to ADDR_W bits.
SIGN_EXT_BYTE, 1, 1 = byte loads sign-extend bit 7; 0 = zero-extend.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  synchronous, active-high reset.
cpu_req  in  1  request; sampled only in IDLE.
cpu_we  in  1  1 = store, 0 = load.
cpu_size  in  1  0 = byte, 1 = word.
cpu_addr  in  32  byte address; bits [ADDR_W-1:0] used.
cpu_wdata  in  32  store data; a byte store uses [7:0].
cpu_rdata  out  32  load result; valid while cpu_done=1 and held until the next load completes.
cpu_busy  out  1  high from the cycle after acceptance through the DONE cycle.
cpu_done  out  1  one-cycle completion pulse.
ram_addr  out  ADDR_W  RAM byte address.
ram_wdata  out  8  RAM write byte.
ram_we  out  1  RAM write enable.
ram_rdata  in  8  RAM read byte; synchronous RAM, valid 1 cycle after ram_addr.

Behaviour:
- Reset: state=IDLE, idx=0, cpu_rdata=0, cpu_busy=0, cpu_done=0, ram_we=0, ram_addr=0, ram_wdata=0. Reset wins over every other event.
- States are IDLE, XFER, TAIL, DONE.
- IDLE:
  - ram_* outputs driven to 0.
  - If cpu_req=1 at the edge: latch addr, we, size, wdata; set idx=0; go to XFER.
- XFER, per cycle:
  - ram_addr = (base + idx) mod 2^ADDR_W.
  - ram_we = latched we.
  - ram_wdata = wdata byte[idx].
  - For loads with idx>0: capture ram_rdata into byte[idx-1] of the assembly register.
  - Let N = 1 (byte) or 4 (word). When idx = N-1: a load goes to TAIL, a store goes to DONE. Otherwise idx++.
- TAIL (loads only):
  - ram_we=0.
  - Capture ram_rdata into byte[N-1].
  - Go to DONE.
- DONE:
  - cpu_done=1.
  - For loads, cpu_rdata is the assembled value: byte loads are sign- or zero-extended per SIGN_EXT_BYTE; word loads are {b3,b2,b1,b0}.
  - Go to IDLE unconditionally.
  - cpu_rdata is registered on entry to DONE.
- Latency, with the request accepted at edge T:
  - Word load: done high in cycle T+6.
  - Byte load: done high in cycle T+3.
  - Word store: done high in cycle T+5.
  - Byte store: done high in cycle T+2.
- Stores leave cpu_rdata unchanged.
- The CPU must drop cpu_req in the DONE cycle. A req still high in IDLE after DONE starts a new transaction; this is legal and gives back-to-back accesses.
- cpu_req and the other cpu_* inputs are ignored outside IDLE. The latched copies are used throughout the transaction.
- Misaligned words are allowed. Addresses wrap at 2^ADDR_W; for example, base 0x3FE accesses 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-store: the next cycle has ram_we=0. Bytes already written stay written; there is no rollback.
- Reset mid-load: the partial result is discarded and cpu_rdata becomes 0.

Decomposition:
- Package word_mem_bridge_pkg holds:
  - state enum (IDLE, XFER, TAIL, DONE);
  - localparams SIZE_BYTE=1'b0 and SIZE_WORD=1'b1;
  - localparam WORD_BYTES=4.
- One sub-module, byte_lane_assembler:
  - takes the capture enable, lane index and ram_rdata;
  - holds the 32-bit assembly register;
  - outputs the extended/packed result.
- The FSM, index counter and address adder stay in the top module.

Test Plan:
- Word store, addr 0x010, wdata 0xDEADBEEF -> ram writes 0x010=EF, 0x011=BE, 0x012=AD, 0x013=DE, one per cycle; done pulses at T+5; busy high T+1..T+5.
- Word load of the same address, RAM model with 1-cycle read latency -> cpu_rdata=0xDEADBEEF, done at T+6, ram_we never asserted.
- Byte load, addr 0x020 holding 0x80 -> cpu_rdata=0xFFFFFF80 (SIGN_EXT_BYTE=1); repeat with SIGN_EXT_BYTE=0 -> 0x00000080; done at T+3.
- Word store at addr 0x3FE, wdata 0x11223344 -> writes 0x3FE=44, 0x3FF=33, 0x000=22, 0x001=11.
- Reset asserted during the 2nd XFER cycle of a word store -> next cycle ram_we=0 and all outputs at reset values; only byte 0 is written; a following word load returns the old upper bytes.
- cpu_req held high across two word loads, with cpu_addr changed mid-transaction -> first load uses the latched address; second starts the cycle after DONE; each done is exactly one cycle.
